// File: rtl/regfield_pkg.sv
// Shared types and constants for the 8-bit register field at addresses 48..50
// and the arbiters that front it.
package regfield_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [7:0] RF_ADDR_LO   = 8'd48;
    localparam logic [7:0] RF_ADDR_HI   = 8'd50;
    localparam logic [7:0] RF_IDLE_ADDR = 8'h00;

    function automatic logic addr_in_range(input logic [7:0] addr,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/regfield_arbiter_rr_picker.sv
// Combinational round-robin picker: searches upward from last+1 (mod N) and
// returns the first requesting index as one-hot plus binary index.
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] winner_idx,
    output logic          valid
);

    always_comb begin
        int idx;
        idx        = 0;
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!valid && req[IW'(idx)]) begin
                valid              = 1'b1;
                winner[IW'(idx)]   = 1'b1;
                winner_idx         = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfield_arbiter.sv
// Round-robin arbiter sequencing one read or write at a time from N_REQ
// requesters onto the falling-edge register field; all outputs registered.
module regfield_arbiter
    import regfield_pkg::*;
#(
    parameter int         N_REQ   = 3,
    parameter logic [7:0] ADDR_LO = RF_ADDR_LO,
    parameter logic [7:0] ADDR_HI = RF_ADDR_HI
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      req_we,
    input  logic [N_REQ-1:0][7:0] req_addr,
    input  logic [N_REQ-1:0][7:0] req_wdata,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic                  err,
    output logic [7:0]            rdata,
    output logic [7:0]            rf_addr,
    output logic [7:0]            rf_wdata,
    output logic                  rf_we,
    input  logic [7:0]            rf_rdata
);

    localparam int IW = $clog2(N_REQ);

    state_t           state_reg, state_next;
    logic [IW-1:0]    last_reg, last_next;
    logic [N_REQ-1:0] winner_reg, winner_next;
    logic             we_reg, we_next;
    logic             ok_reg, ok_next;

    logic [N_REQ-1:0] gnt_next, done_next;
    logic             err_next, rf_we_next;
    logic [7:0]       rdata_next, rf_addr_next, rf_wdata_next;

    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic             pick_ok;

    rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
        .req        (req),
        .last       (last_reg),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    assign pick_ok = addr_in_range(req_addr[pick_idx], ADDR_LO, ADDR_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        winner_next   = winner_reg;
        we_next       = we_reg;
        ok_next       = ok_reg;
        gnt_next      = '0;
        done_next     = '0;
        err_next      = 1'b0;
        rdata_next    = 8'h00;
        rf_addr_next  = RF_IDLE_ADDR;
        rf_wdata_next = 8'h00;
        rf_we_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next   = ACCESS;
                    last_next    = pick_idx;
                    winner_next  = pick_onehot;
                    we_next      = req_we[pick_idx];
                    ok_next      = pick_ok;
                    gnt_next     = pick_onehot;
                    rf_addr_next = req_addr[pick_idx];
                    // Out-of-range writes never reach the field.
                    if (req_we[pick_idx] && pick_ok) begin
                        rf_we_next    = 1'b1;
                        rf_wdata_next = req_wdata[pick_idx];
                    end
                end
            end
            ACCESS: begin
                state_next = RESP;
                done_next  = winner_reg;
                err_next   = !ok_reg;
                // rf_rdata was registered by the field at the mid-ACCESS falling edge.
                if (ok_reg && !we_reg) rdata_next = rf_rdata;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg   <= IW'(N_REQ - 1);
            winner_reg <= '0;
            we_reg     <= 1'b0;
            ok_reg     <= 1'b0;
            gnt        <= '0;
            done       <= '0;
            err        <= 1'b0;
            rdata      <= 8'h00;
            rf_addr    <= RF_IDLE_ADDR;
            rf_wdata   <= 8'h00;
            rf_we      <= 1'b0;
        end else begin
            last_reg   <= last_next;
            winner_reg <= winner_next;
            we_reg     <= we_next;
            ok_reg     <= ok_next;
            gnt        <= gnt_next;
            done       <= done_next;
            err        <= err_next;
            rdata      <= rdata_next;
            rf_addr    <= rf_addr_next;
            rf_wdata   <= rf_wdata_next;
            rf_we      <= rf_we_next;
        end
    end

endmodule
